pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives stall (enable-low) and flush (bubble-insert) controls for the F/D, D/E, E/M and M/W pipeline registers, and generates the operand forwarding selects for the execute stage. It also runs a small FSM that:
- flushes the pipe after reset, and
- freezes the whole pipeline while a multi-cycle data-memory access in M is outstanding, with timeout and error reporting.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_forward_unit.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller and its
// forwarding compare units.
package hazard_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF          = 2'b00;
    localparam logic [1:0] FWD_W           = 2'b01;
    localparam logic [1:0] FWD_M           = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // x0 is hardwired to zero, so a write to it is never a real dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational operand-forwarding select for one execute-stage source.
// The M result is newer than W, so it takes priority.
module hazard_forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_w && reg_match(rd_w, rs_e))
            fwd = FWD_W;
        if (reg_write_m && reg_match(rd_m, rs_e))
            fwd = FWD_M;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage pipeline: post-reset flush,
// memory-wait freeze with timeout, branch flush, load-use stall, forwarding.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int INIT_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_e,
    input  logic [4:0]  rd_m,
    input  logic [4:0]  rd_w,
    input  logic        reg_write_m,
    input  logic        reg_write_w,
    input  logic [1:0]  result_src_e,
    input  logic        pc_src_e,
    input  logic        mem_access_m,
    input  logic        dmem_ready,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_m,
    output logic        flush_w,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    localparam int INIT_W = (INIT_FLUSH_CYCLES > 1) ? $clog2(INIT_FLUSH_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    state_e              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [31:0]         stall_cycles_q, stall_cycles_d;

    logic mem_wait;
    logic load_use;
    logic run_eval;

    hazard_forward_unit u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd         (forward_a_e)
    );

    hazard_forward_unit u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd         (forward_b_e)
    );

    assign mem_wait = mem_access_m && !dmem_ready;
    assign load_use = (result_src_e == RESULT_SRC_LOAD) &&
                      (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));

    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        flush_w    = 1'b0;
        run_eval   = 1'b0;
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;

        case (state_q)
            INIT: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
                flush_m = 1'b1;
                flush_w = 1'b1;
                if (init_cnt_q == '0)
                    state_d = RUN;
                else
                    init_cnt_d = init_cnt_q - INIT_W'(1);
            end
            RUN: begin
                if (mem_wait) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    flush_w    = 1'b1;
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end else begin
                    run_eval = 1'b1;
                end
            end
            WAIT: begin
                // Completion beats timeout when both land in the same cycle.
                if (dmem_ready) begin
                    run_eval = 1'b1;
                    state_d  = RUN;
                end else if (wait_cnt_q == TIMEOUT_V) begin
                    flush_w   = 1'b1;
                    state_d   = RUN;
                    mem_err_d = 1'b1;
                end else begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    flush_w    = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // A taken branch squashes the dependent instruction anyway, so it
        // overrides the load-use stall.
        if (run_eval) begin
            if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end

        stall_cycles_d = stall_cycles_q;
        if (state_q != INIT && stall_f && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= INIT;
            init_cnt_q     <= INIT_LOAD;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (INIT_FLUSH_CYCLES=2, MEM_TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        reg_write_m, reg_write_w;
    logic [1:0]  result_src_e;
    logic        pc_src_e, mem_access_m, dmem_ready;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_m, flush_w;
    logic [1:0]  forward_a_e, forward_b_e;
    logic        mem_err;
    logic [31:0] stall_cycles;

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}
    logic [7:0]  ctl;
    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};

    localparam logic [7:0] CTL_INIT   = 8'b1000_1111;
    localparam logic [7:0] CTL_FREEZE = 8'b1111_0001;
    localparam logic [7:0] CTL_LU     = 8'b1100_0100;
    localparam logic [7:0] CTL_BR     = 8'b0000_1100;
    localparam logic [7:0] CTL_ABORT  = 8'b0000_0001;
    localparam logic [7:0] CTL_NONE   = 8'b0000_0000;

    int vec  = 0;
    int errs = 0;

    pipeline_hazard_ctrl #(.INIT_FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .rd_m         (rd_m),
        .rd_w         (rd_w),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .result_src_e (result_src_e),
        .pc_src_e     (pc_src_e),
        .mem_access_m (mem_access_m),
        .dmem_ready   (dmem_ready),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_m      (flush_m),
        .flush_w      (flush_w),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_in();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        reg_write_m = 0; reg_write_w = 0; result_src_e = 2'b00;
        pc_src_e = 0; mem_access_m = 0; dmem_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr_in();
        @(negedge clk); @(negedge clk); #1;
        vec++; if (ctl !== CTL_INIT) begin errs++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_INIT); end
        vec++; if (mem_err !== 1'b0) begin errs++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
        vec++; if (stall_cycles !== 32'd0) begin errs++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
        rst_n = 1'b1;
        #1;
        vec++; if (ctl !== CTL_INIT) begin errs++; $display("FAIL init_cycle1: got %b want %b", ctl, CTL_INIT); end
        @(negedge clk); #1;
        vec++; if (ctl !== CTL_INIT) begin errs++; $display("FAIL init_cycle2: got %b want %b", ctl, CTL_INIT); end
        @(negedge clk); #1;
        vec++; if (ctl !== CTL_NONE) begin errs++; $display("FAIL init_done: got %b want %b", ctl, CTL_NONE); end
        vec++; if (stall_cycles !== 32'd0) begin errs++; $display("FAIL init_stall_cycles: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_forward();
        @(negedge clk);
        rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5; rs2_e = 5;
        #1;
        vec++; if (forward_a_e !== 2'b10) begin errs++; $display("FAIL fwd_a_m_prio: got %b want 10", forward_a_e); end
        vec++; if (forward_b_e !== 2'b10) begin errs++; $display("FAIL fwd_b_m_prio: got %b want 10", forward_b_e); end
        rd_m = 0; #1;
        vec++; if (forward_a_e !== 2'b01) begin errs++; $display("FAIL fwd_a_w: got %b want 01", forward_a_e); end
        rd_m = 5; reg_write_m = 0; #1;
        vec++; if (forward_a_e !== 2'b01) begin errs++; $display("FAIL fwd_a_m_nowrite: got %b want 01", forward_a_e); end
        rs2_e = 0; rd_w = 0; reg_write_m = 1; rd_m = 9; #1;
        vec++; if (forward_b_e !== 2'b00) begin errs++; $display("FAIL fwd_b_rf: got %b want 00", forward_b_e); end
        vec++; if (forward_a_e !== 2'b00) begin errs++; $display("FAIL fwd_a_rf: got %b want 00", forward_a_e); end
        clr_in();
    endtask

    task automatic test_mem_miss();
        @(negedge clk);
        mem_access_m = 1; dmem_ready = 0; #1;
        vec++; if (ctl !== CTL_FREEZE) begin errs++; $display("FAIL miss_c1: got %b want %b", ctl, CTL_FREEZE); end
        @(negedge clk);
        pc_src_e = 1; result_src_e = 2'b01; rd_e = 7; rs1_d = 7; #1;
        vec++; if (ctl !== CTL_FREEZE) begin errs++; $display("FAIL miss_c2_ignore_branch: got %b want %b", ctl, CTL_FREEZE); end
        @(negedge clk);
        pc_src_e = 0; result_src_e = 2'b00; rd_e = 0; rs1_d = 0; #1;
        vec++; if (ctl !== CTL_FREEZE) begin errs++; $display("FAIL miss_c3: got %b want %b", ctl, CTL_FREEZE); end
        @(negedge clk);
        dmem_ready = 1; #1;
        vec++; if (ctl !== CTL_NONE) begin errs++; $display("FAIL miss_release: got %b want %b", ctl, CTL_NONE); end
        @(negedge clk);
        clr_in(); #1;
        vec++; if (stall_cycles !== 32'd3) begin errs++; $display("FAIL miss_stall_cycles: got %0d want 3", stall_cycles); end
        vec++; if (ctl !== CTL_NONE) begin errs++; $display("FAIL miss_after: got %b want %b", ctl, CTL_NONE); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7; #1;
        vec++; if (ctl !== CTL_LU) begin errs++; $display("FAIL load_use: got %b want %b", ctl, CTL_LU); end
        @(negedge clk);
        pc_src_e = 1; #1;
        vec++; if (ctl !== CTL_BR) begin errs++; $display("FAIL load_use_branch: got %b want %b", ctl, CTL_BR); end
        vec++; if (stall_cycles !== 32'd4) begin errs++; $display("FAIL lu_stall_cycles: got %0d want 4", stall_cycles); end
        @(negedge clk);
        pc_src_e = 0; rd_e = 0; rs2_d = 0; #1;
        vec++; if (ctl !== CTL_NONE) begin errs++; $display("FAIL load_use_x0: got %b want %b", ctl, CTL_NONE); end
        rd_e = 7; rs1_d = 7; result_src_e = 2'b00; #1;
        vec++; if (ctl !== CTL_NONE) begin errs++; $display("FAIL no_load_no_stall: got %b want %b", ctl, CTL_NONE); end
        result_src_e = 2'b01; #1;
        vec++; if (ctl !== CTL_LU) begin errs++; $display("FAIL load_use_rs1: got %b want %b", ctl, CTL_LU); end
        @(negedge clk);
        clr_in(); #1;
        vec++; if (stall_cycles !== 32'd5) begin errs++; $display("FAIL lu2_stall_cycles: got %0d want 5", stall_cycles); end
    endtask

    // Ready arriving in the would-be abort cycle completes the access.
    task automatic test_ready_wins();
        @(negedge clk);
        mem_access_m = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vec++; if (ctl !== CTL_FREEZE) begin errs++; $display("FAIL rw_freeze%0d: got %b want %b", i, ctl, CTL_FREEZE); end
            @(negedge clk);
        end
        dmem_ready = 1; #1;
        vec++; if (ctl !== CTL_NONE) begin errs++; $display("FAIL rw_release: got %b want %b", ctl, CTL_NONE); end
        @(negedge clk);
        clr_in(); #1;
        vec++; if (mem_err !== 1'b0) begin errs++; $display("FAIL rw_mem_err: got %b want 0", mem_err); end
        vec++; if (stall_cycles !== 32'd10) begin errs++; $display("FAIL rw_stall_cycles: got %0d want 10", stall_cycles); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        mem_access_m = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vec++; if (ctl !== CTL_FREEZE) begin errs++; $display("FAIL to_freeze%0d: got %b want %b", i, ctl, CTL_FREEZE); end
            @(negedge clk);
        end
        #1;
        vec++; if (ctl !== CTL_ABORT) begin errs++; $display("FAIL to_abort: got %b want %b", ctl, CTL_ABORT); end
        vec++; if (mem_err !== 1'b0) begin errs++; $display("FAIL to_err_early: got %b want 0", mem_err); end
        @(negedge clk);
        clr_in(); #1;
        vec++; if (mem_err !== 1'b1) begin errs++; $display("FAIL to_err_set: got %b want 1", mem_err); end
        vec++; if (ctl !== CTL_NONE) begin errs++; $display("FAIL to_after: got %b want %b", ctl, CTL_NONE); end
        vec++; if (stall_cycles !== 32'd15) begin errs++; $display("FAIL to_stall_cycles: got %0d want 15", stall_cycles); end
        repeat (3) @(negedge clk);
        #1;
        vec++; if (mem_err !== 1'b1) begin errs++; $display("FAIL to_err_sticky: got %b want 1", mem_err); end
    endtask

    task automatic test_reset_mid_wait();
        test_reset();
        @(negedge clk);
        mem_access_m = 1; dmem_ready = 0;
        @(negedge clk); @(negedge clk);
        #1;
        vec++; if (ctl !== CTL_FREEZE) begin errs++; $display("FAIL mw_in_wait: got %b want %b", ctl, CTL_FREEZE); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if (ctl !== CTL_INIT) begin errs++; $display("FAIL mw_async_init: got %b want %b", ctl, CTL_INIT); end
        vec++; if (stall_cycles !== 32'd0) begin errs++; $display("FAIL mw_stall_cycles: got %0d want 0", stall_cycles); end
        repeat (6) @(negedge clk);
        #1;
        vec++; if (mem_err !== 1'b0) begin errs++; $display("FAIL mw_mem_err: got %b want 0", mem_err); end
        clr_in();
        rst_n = 1'b1; #1;
        vec++; if (ctl !== CTL_INIT) begin errs++; $display("FAIL mw_init1: got %b want %b", ctl, CTL_INIT); end
        @(negedge clk); #1;
        vec++; if (ctl !== CTL_INIT) begin errs++; $display("FAIL mw_init2: got %b want %b", ctl, CTL_INIT); end
        @(negedge clk); #1;
        vec++; if (ctl !== CTL_NONE) begin errs++; $display("FAIL mw_run: got %b want %b", ctl, CTL_NONE); end
        vec++; if (mem_err !== 1'b0) begin errs++; $display("FAIL mw_mem_err_after: got %b want 0", mem_err); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_mem_miss();
        test_load_use();
        test_ready_wins();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
